dcache_responder: RTL and testbench

Direct-mapped, write-back, write-allocate data cache that answers the pipeline's MEM-stage memory requests and refills or evicts whole lines over a valid/ready request channel to backing data memory. On a hit it answers combinationally in the same cycle. On a miss it drops `is_ready`, which stalls the pipeline, and runs a writeback/allocate FSM until the retried access hits.

---
 rtl/dcache_pkg.sv | 36 +++
 rtl/dcache_line_array.sv | 60 ++++++
 rtl/dcache_responder.sv | 159 +++++++++++++++
 tb/tb_dcache_responder.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared types and constants for the direct-mapped write-back data cache.
// FSM state encoding, address field widths and small address/line helpers.
package dcache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WB_REQ,
    WB_WAIT,
    ALLOC_REQ,
    ALLOC_WAIT
  } state_e;

  localparam int ADDR_W   = 32;
  localparam int WORD_W   = 32;
  localparam int TAG_W    = 24;
  localparam int INDEX_W  = 4;
  localparam int OFFSET_W = 2;
  localparam int LINE_W   = 128;

  // Line-aligned byte address from a tag and set index.
  function automatic logic [ADDR_W-1:0] line_addr(
    input logic [TAG_W-1:0]   tag,
    input logic [INDEX_W-1:0] idx
  );
    return {tag, idx, {(ADDR_W-TAG_W-INDEX_W){1'b0}}};
  endfunction

  // One 32-bit word out of a line, word 0 in the low bits.
  function automatic logic [WORD_W-1:0] word_sel(
    input logic [LINE_W-1:0]   line,
    input logic [OFFSET_W-1:0] w
  );
    return line[int'(w)*WORD_W +: WORD_W];
  endfunction

endpackage

// File: rtl/dcache_line_array.sv
// Tag/valid/dirty/data storage for the direct-mapped cache.
// Ports: idx_i selects the set for the combinational read and all writes;
// word write (store hit), line fill (refill) and dirty clear (after evict).
module dcache_line_array
  import dcache_pkg::*;
#(
  parameter int NUM_SETS   = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic [INDEX_W-1:0]           idx_i,
  output logic                         rd_valid_o,
  output logic                         rd_dirty_o,
  output logic [TAG_W-1:0]             rd_tag_o,
  output logic [LINE_WORDS*WORD_W-1:0] rd_line_o,
  input  logic                         wr_word_en_i,
  input  logic [OFFSET_W-1:0]          wr_word_i,
  input  logic [WORD_W-1:0]            wr_data_i,
  input  logic                         fill_en_i,
  input  logic [TAG_W-1:0]             fill_tag_i,
  input  logic [LINE_WORDS*WORD_W-1:0] fill_line_i,
  input  logic                         clr_dirty_i
);

  logic [NUM_SETS-1:0]           valid_q;
  logic [NUM_SETS-1:0]           dirty_q;
  logic [TAG_W-1:0]              tag_q  [NUM_SETS];
  logic [LINE_WORDS*WORD_W-1:0]  data_q [NUM_SETS];

  assign rd_valid_o = valid_q[idx_i];
  assign rd_dirty_o = dirty_q[idx_i];
  assign rd_tag_o   = tag_q[idx_i];
  assign rd_line_o  = data_q[idx_i];

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_en_i) begin
      valid_q[idx_i] <= 1'b1;
      dirty_q[idx_i] <= 1'b0;
    end else if (wr_word_en_i) begin
      dirty_q[idx_i] <= 1'b1;
    end else if (clr_dirty_i) begin
      dirty_q[idx_i] <= 1'b0;
    end
  end

  // Payload needs no reset: it is only observed behind a valid bit.
  always_ff @(posedge clk_i) begin
    if (fill_en_i) begin
      tag_q[idx_i]  <= fill_tag_i;
      data_q[idx_i] <= fill_line_i;
    end else if (wr_word_en_i) begin
      data_q[idx_i][int'(wr_word_i)*WORD_W +: WORD_W] <= wr_data_i;
    end
  end

endmodule

// File: rtl/dcache_responder.sv
// Direct-mapped write-back/write-allocate D-cache for the MEM stage.
// Hits answer combinationally; misses stall via is_ready and run evict/refill.
module dcache_responder
  import dcache_pkg::*;
#(
  parameter int NUM_SETS   = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         is_input_valid,
  input  logic [ADDR_W-1:0]            addr,
  input  logic [WORD_W-1:0]            din,
  input  logic                         mem_rw,
  output logic                         is_ready,
  output logic                         is_output_valid,
  output logic                         is_hit,
  output logic [WORD_W-1:0]            dout,
  output logic                         mem_req_valid,
  output logic                         mem_req_rw,
  output logic [ADDR_W-1:0]            mem_req_addr,
  output logic [LINE_WORDS*WORD_W-1:0] mem_req_din,
  input  logic                         mem_req_ready,
  input  logic                         mem_resp_valid,
  input  logic [LINE_WORDS*WORD_W-1:0] mem_resp_dout,
  output logic [31:0]                  hit_count,
  output logic [31:0]                  miss_count
);

  state_e                       state_q;
  logic                         req_valid_q;
  logic                         req_rw_q;
  logic [ADDR_W-1:0]            req_addr_q;
  logic [LINE_WORDS*WORD_W-1:0] req_din_q;
  logic [31:0]                  hit_cnt_q;
  logic [31:0]                  miss_cnt_q;

  logic [TAG_W-1:0]             a_tag;
  logic [INDEX_W-1:0]           a_idx;
  logic [OFFSET_W-1:0]          a_word;
  logic                         unused_addr_bits;

  logic                         rd_valid;
  logic                         rd_dirty;
  logic [TAG_W-1:0]             rd_tag;
  logic [LINE_WORDS*WORD_W-1:0] rd_line;

  logic                         in_idle;
  logic                         hit;
  logic                         miss;
  logic                         fill_en;
  logic                         clr_dirty;

  assign a_tag  = addr[ADDR_W-1 -: TAG_W];
  assign a_idx  = addr[OFFSET_W+2 +: INDEX_W];
  assign a_word = addr[2 +: OFFSET_W];
  assign unused_addr_bits = ^addr[1:0];

  assign in_idle   = (state_q == IDLE);
  assign hit       = in_idle && is_input_valid
                     && rd_valid && (rd_tag == a_tag);
  assign miss      = in_idle && is_input_valid && !hit;
  assign fill_en   = (state_q == ALLOC_WAIT) && mem_resp_valid;
  assign clr_dirty = (state_q == WB_WAIT) && mem_resp_valid;

  assign is_ready        = in_idle && !miss;
  assign is_hit          = hit;
  assign is_output_valid = hit && !mem_rw;
  assign dout            = is_output_valid ? word_sel(rd_line, a_word)
                                           : '0;

  assign mem_req_valid = req_valid_q;
  assign mem_req_rw    = req_rw_q;
  assign mem_req_addr  = req_addr_q;
  assign mem_req_din   = req_din_q;
  assign hit_count     = hit_cnt_q;
  assign miss_count    = miss_cnt_q;

  dcache_line_array #(
    .NUM_SETS   (NUM_SETS),
    .LINE_WORDS (LINE_WORDS)
  ) u_lines (
    .clk_i        (clk),
    .reset_i      (reset),
    .idx_i        (a_idx),
    .rd_valid_o   (rd_valid),
    .rd_dirty_o   (rd_dirty),
    .rd_tag_o     (rd_tag),
    .rd_line_o    (rd_line),
    .wr_word_en_i (hit && mem_rw),
    .wr_word_i    (a_word),
    .wr_data_i    (din),
    .fill_en_i    (fill_en),
    .fill_tag_i   (a_tag),
    .fill_line_i  (mem_resp_dout),
    .clr_dirty_i  (clr_dirty)
  );

  // Request fields are loaded one state ahead so they are plain registers
  // while the memory side holds off with mem_req_ready low.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      req_valid_q <= 1'b0;
      req_rw_q    <= 1'b0;
      req_addr_q  <= '0;
      req_din_q   <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (hit) hit_cnt_q <= hit_cnt_q + 32'd1;
          if (miss) begin
            miss_cnt_q  <= miss_cnt_q + 32'd1;
            req_valid_q <= 1'b1;
            if (rd_valid && rd_dirty) begin
              state_q    <= WB_REQ;
              req_rw_q   <= 1'b1;
              req_addr_q <= line_addr(rd_tag, a_idx);
              req_din_q  <= rd_line;
            end else begin
              state_q    <= ALLOC_REQ;
              req_rw_q   <= 1'b0;
              req_addr_q <= line_addr(a_tag, a_idx);
              req_din_q  <= '0;
            end
          end
        end
        WB_REQ: begin
          if (mem_req_ready) begin
            req_valid_q <= 1'b0;
            state_q     <= WB_WAIT;
          end
        end
        WB_WAIT: begin
          if (mem_resp_valid) begin
            state_q     <= ALLOC_REQ;
            req_valid_q <= 1'b1;
            req_rw_q    <= 1'b0;
            req_addr_q  <= line_addr(a_tag, a_idx);
            req_din_q   <= '0;
          end
        end
        ALLOC_REQ: begin
          if (mem_req_ready) begin
            req_valid_q <= 1'b0;
            state_q     <= ALLOC_WAIT;
          end
        end
        ALLOC_WAIT: begin
          if (mem_resp_valid) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_responder.sv
// Directed bench for dcache_responder with a line-granular memory model.
// Ports: drives the pipeline side and answers mem_req_* with fixed latency.
module tb_dcache_responder;

  logic         clk = 1'b0;
  logic         reset;
  logic         is_input_valid;
  logic [31:0]  addr;
  logic [31:0]  din;
  logic         mem_rw;
  logic         is_ready;
  logic         is_output_valid;
  logic         is_hit;
  logic [31:0]  dout;
  logic         mem_req_valid;
  logic         mem_req_rw;
  logic [31:0]  mem_req_addr;
  logic [127:0] mem_req_din;
  logic         mem_req_ready;
  logic         mem_resp_valid;
  logic [127:0] mem_resp_dout;
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;

  always #5 clk = ~clk;

  dcache_responder dut (
    .clk             (clk),
    .reset           (reset),
    .is_input_valid  (is_input_valid),
    .addr            (addr),
    .din             (din),
    .mem_rw          (mem_rw),
    .is_ready        (is_ready),
    .is_output_valid (is_output_valid),
    .is_hit          (is_hit),
    .dout            (dout),
    .mem_req_valid   (mem_req_valid),
    .mem_req_rw      (mem_req_rw),
    .mem_req_addr    (mem_req_addr),
    .mem_req_din     (mem_req_din),
    .mem_req_ready   (mem_req_ready),
    .mem_resp_valid  (mem_resp_valid),
    .mem_resp_dout   (mem_resp_dout),
    .hit_count       (hit_count),
    .miss_count      (miss_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [127:0] mem [256];
  bit           ready_en = 1'b1;
  int           lat      = 3;
  bit           stray    = 1'b0;

  bit           pend = 1'b0;
  int           cnt  = 0;
  logic         p_rw;
  logic [31:0]  p_addr;
  logic [127:0] p_din;

  logic         log_rw   [$];
  logic [31:0]  log_addr [$];
  logic [127:0] log_din  [$];

  // Memory side: acts on negedges; control knobs change only after them.
  initial begin
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_dout  = '0;
    forever begin
      @(negedge clk);
      mem_resp_valid = 1'b0;
      if (reset) begin
        pend          = 1'b0;
        mem_req_ready = 1'b0;
      end else begin
        if (stray) begin
          stray          = 1'b0;
          mem_resp_valid = 1'b1;
          mem_resp_dout  = {4{32'hBAD0BAD0}};
        end
        if (pend) begin
          cnt--;
          if (cnt <= 0) begin
            pend           = 1'b0;
            mem_resp_valid = 1'b1;
            if (p_rw) mem[p_addr[11:4]] = p_din;
            else      mem_resp_dout     = mem[p_addr[11:4]];
          end
        end
        mem_req_ready = ready_en && !pend;
        if (mem_req_ready && mem_req_valid) begin
          pend   = 1'b1;
          cnt    = lat;
          p_rw   = mem_req_rw;
          p_addr = mem_req_addr;
          p_din  = mem_req_din;
          log_rw.push_back(mem_req_rw);
          log_addr.push_back(mem_req_addr);
          log_din.push_back(mem_req_din);
        end
      end
    end
  end

  task automatic clear_log();
    log_rw.delete();
    log_addr.delete();
    log_din.delete();
  endtask

  task automatic access(
    input  logic        rw,
    input  logic [31:0] a,
    input  logic [31:0] d,
    output int          stall,
    output logic [31:0] rdata,
    output logic        hit,
    output logic        ov
  );
    @(negedge clk);
    is_input_valid = 1'b1;
    mem_rw = rw;
    addr   = a;
    din    = d;
    #1;
    stall = 0;
    while (!is_ready && stall < 200) begin
      stall++;
      @(negedge clk);
      #1;
    end
    rdata = dout;
    hit   = is_hit;
    ov    = is_output_valid;
    @(negedge clk);
    is_input_valid = 1'b0;
    mem_rw = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    is_input_valid = 1'b0;
    addr = '0;
    din  = '0;
    mem_rw = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    n_tests++;
    if (is_ready !== 1'b1 || dout !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_idle: ready=%b dout=%h want 1/0", is_ready, dout);
    end
    n_tests++;
    if (mem_req_valid !== 1'b0 || mem_req_rw !== 1'b0 ||
        mem_req_addr !== 32'h0 || mem_req_din !== 128'h0) begin
      n_fail++;
      $display("FAIL reset_req: v=%b rw=%b a=%h want all 0",
               mem_req_valid, mem_req_rw, mem_req_addr);
    end
    n_tests++;
    if (hit_count !== 32'd0 || miss_count !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_cnt: hit=%0d miss=%0d want 0/0",
               hit_count, miss_count);
    end
  endtask

  task automatic test_cold_load();
    int st; logic [31:0] d; logic h, ov;
    lat = 3;
    access(1'b0, 32'h0000_0100, 32'h0, st, d, h, ov);
    n_tests++;
    if (st !== 5) begin
      n_fail++;
      $display("FAIL cold_stall: got %0d want 5", st);
    end
    n_tests++;
    if (h !== 1'b1 || ov !== 1'b1 || d !== 32'd1) begin
      n_fail++;
      $display("FAIL cold_data: hit=%b ov=%b dout=%h want 1/1/1", h, ov, d);
    end
    n_tests++;
    if (miss_count !== 32'd1 || hit_count !== 32'd1) begin
      n_fail++;
      $display("FAIL cold_cnt: hit=%0d miss=%0d want 1/1",
               hit_count, miss_count);
    end
  endtask

  task automatic test_store_hit();
    int st; logic [31:0] d; logic h, ov;
    access(1'b1, 32'h0000_0104, 32'hDEAD_BEEF, st, d, h, ov);
    n_tests++;
    if (st !== 0 || h !== 1'b1 || ov !== 1'b0) begin
      n_fail++;
      $display("FAIL st_hit: stall=%0d hit=%b ov=%b want 0/1/0", st, h, ov);
    end
    access(1'b0, 32'h0000_0104, 32'h0, st, d, h, ov);
    n_tests++;
    if (st !== 0 || d !== 32'hDEAD_BEEF || ov !== 1'b1) begin
      n_fail++;
      $display("FAIL ld_after_st: stall=%0d dout=%h ov=%b want 0/deadbeef/1",
               st, d, ov);
    end
    n_tests++;
    if (hit_count !== 32'd3) begin
      n_fail++;
      $display("FAIL st_hit_cnt: got %0d want 3", hit_count);
    end
  endtask

  task automatic test_dirty_evict();
    int st; logic [31:0] d; logic h, ov;
    lat = 2;
    clear_log();
    access(1'b0, 32'h0000_0200, 32'h0, st, d, h, ov);
    n_tests++;
    if (st !== 7 || d !== 32'd5 || h !== 1'b1) begin
      n_fail++;
      $display("FAIL evict_load: stall=%0d dout=%h hit=%b want 7/5/1",
               st, d, h);
    end
    n_tests++;
    if (log_rw.size() != 2) begin
      n_fail++;
      $display("FAIL evict_nreq: got %0d want 2", log_rw.size());
    end else begin
      if (log_rw[0] !== 1'b1 || log_addr[0] !== 32'h100 ||
          log_din[0] !== {32'd4, 32'd3, 32'hDEAD_BEEF, 32'd1}) begin
        n_fail++;
        $display("FAIL evict_wb: rw=%b a=%h din=%h want 1/100/..deadbeef_1",
                 log_rw[0], log_addr[0], log_din[0]);
      end
      n_tests++;
      if (log_rw[1] !== 1'b0 || log_addr[1] !== 32'h200) begin
        n_fail++;
        $display("FAIL evict_fill: rw=%b a=%h want 0/200",
                 log_rw[1], log_addr[1]);
      end
    end
    n_tests++;
    if (miss_count !== 32'd2 || hit_count !== 32'd4) begin
      n_fail++;
      $display("FAIL evict_cnt: hit=%0d miss=%0d want 4/2",
               hit_count, miss_count);
    end
  endtask

  task automatic test_hold_ready();
    int k;
    ready_en = 1'b0;
    lat = 1;
    clear_log();
    @(negedge clk);
    is_input_valid = 1'b1;
    mem_rw = 1'b0;
    addr   = 32'h0000_0410;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      n_tests++;
      if (mem_req_valid !== 1'b1 || mem_req_rw !== 1'b0 ||
          mem_req_addr !== 32'h410 || is_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_req%0d: v=%b rw=%b a=%h rdy=%b want 1/0/410/0",
                 i, mem_req_valid, mem_req_rw, mem_req_addr, is_ready);
      end
      if (i == 1) stray = 1'b1;
    end
    ready_en = 1'b1;
    k = 0;
    while (!is_ready && k < 50) begin
      k++;
      @(negedge clk);
      #1;
    end
    n_tests++;
    if (is_hit !== 1'b1 || dout !== 32'h11) begin
      n_fail++;
      $display("FAIL hold_data: hit=%b dout=%h want 1/11", is_hit, dout);
    end
    @(negedge clk);
    is_input_valid = 1'b0;
    #1;
    n_tests++;
    if (log_addr.size() != 1) begin
      n_fail++;
      $display("FAIL hold_nreq: got %0d want 1", log_addr.size());
    end
  endtask

  task automatic test_store_miss();
    int st; logic [31:0] d; logic h, ov;
    lat = 2;
    clear_log();
    access(1'b1, 32'h0000_0308, 32'h1234_5678, st, d, h, ov);
    n_tests++;
    if (st !== 4 || h !== 1'b1 || ov !== 1'b0) begin
      n_fail++;
      $display("FAIL stmiss: stall=%0d hit=%b ov=%b want 4/1/0", st, h, ov);
    end
    n_tests++;
    if (log_rw.size() != 1) begin
      n_fail++;
      $display("FAIL stmiss_nreq: got %0d want 1", log_rw.size());
    end else if (log_rw[0] !== 1'b0 || log_addr[0] !== 32'h300) begin
      n_fail++;
      $display("FAIL stmiss_fill: rw=%b a=%h want 0/300",
               log_rw[0], log_addr[0]);
    end
    access(1'b0, 32'h0000_0308, 32'h0, st, d, h, ov);
    n_tests++;
    if (st !== 0 || d !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL stmiss_ld: stall=%0d dout=%h want 0/12345678", st, d);
    end
    clear_log();
    access(1'b0, 32'h0000_0100, 32'h0, st, d, h, ov);
    n_tests++;
    if (d !== 32'd1 || log_rw.size() != 2) begin
      n_fail++;
      $display("FAIL stmiss_evict: dout=%h nreq=%0d want 1/2",
               d, log_rw.size());
    end else if (log_rw[0] !== 1'b1 || log_addr[0] !== 32'h300 ||
                 log_din[0][95:64] !== 32'h1234_5678 ||
                 log_din[0][31:0] !== 32'd9) begin
      n_fail++;
      $display("FAIL stmiss_wb: rw=%b a=%h din=%h want 1/300/w2=12345678",
               log_rw[0], log_addr[0], log_din[0]);
    end
  endtask

  task automatic test_reset_mid();
    int st; logic [31:0] d; logic h, ov;
    lat = 5;
    @(negedge clk);
    is_input_valid = 1'b1;
    mem_rw = 1'b0;
    addr   = 32'h0000_0500;
    @(negedge clk);
    @(negedge clk);
    #1;
    reset = 1'b1;
    is_input_valid = 1'b0;
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    n_tests++;
    if (is_ready !== 1'b1 || mem_req_valid !== 1'b0 ||
        hit_count !== 32'd0 || miss_count !== 32'd0) begin
      n_fail++;
      $display("FAIL rst_mid: rdy=%b v=%b hit=%0d miss=%0d want 1/0/0/0",
               is_ready, mem_req_valid, hit_count, miss_count);
    end
    stray = 1'b1;
    @(negedge clk);
    #1;
    n_tests++;
    if (is_ready !== 1'b1 || mem_req_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_stray: rdy=%b v=%b want 1/0", is_ready, mem_req_valid);
    end
    lat = 3;
    access(1'b0, 32'h0000_0100, 32'h0, st, d, h, ov);
    n_tests++;
    if (st !== 5 || d !== 32'd1 || miss_count !== 32'd1 ||
        hit_count !== 32'd1) begin
      n_fail++;
      $display("FAIL rst_reload: stall=%0d dout=%h miss=%0d hit=%0d want 5/1/1/1",
               st, d, miss_count, hit_count);
    end
  endtask

  initial begin
    mem[8'h10] = {32'd4, 32'd3, 32'd2, 32'd1};
    mem[8'h20] = {32'd8, 32'd7, 32'd6, 32'd5};
    mem[8'h30] = {32'hC, 32'hB, 32'hA, 32'd9};
    mem[8'h41] = {32'h44, 32'h33, 32'h22, 32'h11};
    mem[8'h50] = {32'h54, 32'h53, 32'h52, 32'h51};
    test_reset();
    test_cold_load();
    test_store_hit();
    test_dirty_evict();
    test_hold_ready();
    test_store_miss();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
